lpcm_rx: RTL

- Synthesizable receive end of the LPCM en/data interface.
- Captures every cycle where `en` is high and checks the sample against the configured resolution (low unused bits must be zero).
- Optionally right-justifies the sample with sign extension, buffers it in a first-word-fall-through FIFO, and presents it on a valid/ready stream.
- Sits behind any LPCM source (DUT output or agent) wherever a back-pressurable consumer is needed; reports mask violations and overflow drops.

---
 rtl/lpcm_rx_if.sv | 21 ++
 rtl/lpcm_rx.sv | 129 ++++++++++++
 2 files changed

// File: rtl/lpcm_rx_if.sv
// LPCM receive bundle: en/data sample strobe in, valid/ready sample stream out.
// The master side drives samples and out_ready. The slave side (lpcm_rx) returns the stream.
interface lpcm_rx_if #(
  parameter int DATA_W = 32
);
  logic              en;
  logic [DATA_W-1:0] data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output en, data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  en, data, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/lpcm_rx.sv
// LPCM receiver: masks/checks samples, optionally right-justifies them, and buffers them in a FWFT FIFO.
// Latency is 2 cycles from en to out_valid. When out_ready is held low, a full FIFO drops new samples and counts each drop.
module lpcm_rx #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  lpcm_rx_if.slave                 io,
  input  logic [5:0]               cfg_bits,
  input  logic                     cfg_rjust,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_mask,
  output logic                     err_overflow,
  output logic [15:0]              drop_count,
  input  logic                     clr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [5:0] FULL_BITS = 6'(DATA_W);

  typedef struct packed {
    logic              vld;
    logic              rjust;
    logic [5:0]        bits;
    logic [DATA_W-1:0] dat;
  } cap_t;

  cap_t              cap_d, cap_q;
  logic [AW-1:0]     wr_ptr_d, wr_ptr_q;
  logic [AW-1:0]     rd_ptr_d, rd_ptr_q;
  logic [LW-1:0]     level_d, level_q;
  logic              err_mask_d, err_mask_q;
  logic              err_ovf_d, err_ovf_q;
  logic [15:0]       drop_cnt_d, drop_cnt_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [5:0]               eff_bits;
  logic [DATA_W-1:0]        keep;
  logic                     mask_hit;
  logic [5:0]               shift;
  logic signed [DATA_W-1:0] sdat;
  logic [DATA_W-1:0]        wr_dat;
  logic                     empty, full, push, pop, push_ok, drop;

  // Capture: keep only the top B bits; anything set below them is a source error.
  always_comb begin
    eff_bits = (cfg_bits == 6'd0 || cfg_bits > FULL_BITS) ? FULL_BITS : cfg_bits;
    keep     = {DATA_W{1'b1}} << (FULL_BITS - eff_bits);
    mask_hit = io.en && (|(io.data & ~keep));
    cap_d       = '0;
    cap_d.vld   = io.en;
    cap_d.rjust = cfg_rjust;
    cap_d.bits  = eff_bits;
    cap_d.dat   = io.data & keep;
  end

  // Formatting uses the config latched with the sample, not the live inputs.
  always_comb begin
    shift = FULL_BITS - cap_q.bits;
    sdat  = cap_q.dat;
    if (cap_q.rjust) wr_dat = sdat >>> shift;
    else             wr_dat = cap_q.dat;
  end

  always_comb begin
    empty   = (level_q == '0);
    full    = (level_q == LW'(DEPTH));
    pop     = !empty && io.out_ready;
    push    = cap_q.vld;
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;

    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;

    level_d = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Error events take priority over a coincident clear.
  always_comb begin
    err_mask_d = clr_err ? 1'b0 : err_mask_q;
    err_ovf_d  = clr_err ? 1'b0 : err_ovf_q;
    drop_cnt_d = clr_err ? 16'd0 : drop_cnt_q;
    if (mask_hit) err_mask_d = 1'b1;
    if (drop) begin
      err_ovf_d = 1'b1;
      if (clr_err)                    drop_cnt_d = 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      err_mask_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      cap_q      <= cap_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      err_mask_q <= err_mask_d;
      err_ovf_q  <= err_ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_dat;
  end

  assign io.out_valid = !empty;
  assign io.out_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign level        = level_q;
  assign err_mask     = err_mask_q;
  assign err_overflow = err_ovf_q;
  assign drop_count   = drop_cnt_q;
endmodule
